alu_cmd_seq: RTL

Command-side sequencer for the 4-bit combinational ALU. Accepts operation commands over a valid/ready handshake and drives the ALU operand and select lines. Captures the result and carry, then returns them over a valid/ready response channel. A result accumulator lets a command reuse the previous result as operand A, so short arithmetic chains run without the host re-supplying intermediate values.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_cmd_seq_if.sv | 39 +++
 rtl/alu_cmd_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU and its command sequencer:
//   - DATA_W        : operand/result width (the ALU width)
//   - OP_*          : ALU operation codes presented on alu_sel
//   - seq_state_e   : sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_cmd_seq_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq_if
// Host-facing command and response channels of the ALU command sequencer.
//   cmd_valid/cmd_ready          : command handshake
//   cmd_sel, cmd_a, cmd_b        : operation code and operands
//   cmd_use_acc                  : take operand A from the result accumulator
//   rsp_valid/rsp_ready          : response handshake
//   rsp_result, rsp_carry        : captured ALU result and carry
//   rsp_count                    : completed-response counter (wraps)
// Modports: master = host side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface alu_cmd_seq_if #(
  parameter int CNT_W = 8
) ();
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_sel;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_use_acc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_carry;
  logic [CNT_W-1:0]  rsp_count;

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_count
  );

endinterface

// File: rtl/alu_cmd_seq.sv
// ---------------------------------------------------------------------------
// alu_cmd_seq
// Command-side sequencer for the 4-bit combinational ALU. Accepts one
// command at a time, holds the ALU operand/select lines in registers,
// captures result and carry after one EXEC cycle and returns them over the
// response channel. A result accumulator can replace operand A so that
// arithmetic chains need no host round trip for intermediate values.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   bus (slave)         : command/response channels (see alu_cmd_seq_if)
//   alu_a/alu_b/alu_sel : registered drive to the ALU
//   alu_result/alu_carry: ALU outputs, sampled at the end of EXEC
// ---------------------------------------------------------------------------
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_seq_if.slave      bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry
);

  seq_state_e        r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [2:0]        r_alu_sel;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_carry;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_rsp_count;

  // FSM plus all operand, response, accumulator and counter registers.
  // cmd_ready/rsp_valid are kept as their own flops so every output is a
  // direct register output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_alu_a      <= {DATA_W{1'b0}};
      r_alu_b      <= {DATA_W{1'b0}};
      r_alu_sel    <= 3'b000;
      r_rsp_result <= {DATA_W{1'b0}};
      r_rsp_carry  <= 1'b0;
      r_acc        <= {DATA_W{1'b0}};
      r_rsp_count  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // cmd_ready is 1 throughout IDLE, so cmd_valid alone is the accept.
          if (bus.cmd_valid) begin
            r_alu_a     <= bus.cmd_use_acc ? r_acc : bus.cmd_a;
            r_alu_b     <= bus.cmd_b;
            r_alu_sel   <= bus.cmd_sel;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_carry  <= alu_carry;
          r_acc        <= alu_result;
          r_rsp_valid  <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_count <= r_rsp_count + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean idle.
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.rsp_count  = r_rsp_count;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_sel        = r_alu_sel;

endmodule
